// File: rtl/text_pkg.sv
// Shared constants and types for the VGA text console writer.
// Used by text_console_writer and its tile RAM.
package text_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    localparam logic [6:0] CH_NL       = 7'h0A;
    localparam logic [6:0] CH_BS       = 7'h08;
    localparam logic [6:0] CH_FF       = 7'h0C;
    localparam logic [6:0] CH_BLANK    = 7'h00;
    localparam logic [6:0] CH_PRINT_LO = 7'h20;
    localparam logic [6:0] CH_PRINT_HI = 7'h7E;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_CLR_LINE
    } state_t;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_console_writer_tile_ram.sv
// Simple dual-port tile RAM: one synchronous write port, one registered read port.
// Contents are never reset so the array maps onto block RAM; only the read register resets.
module tile_ram #(
    parameter int AW    = 12,
    parameter int DW    = 7,
    parameter int DEPTH = 2400
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a same-address write this cycle is not visible until the next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer into a COLS x ROWS tile RAM with cursor, control codes and row wrap.
// Optional cursor blink is enabled by defining TEXT_CURSOR_BLINK_EN.
module text_console_writer
    import text_pkg::*;
#(
    parameter int COLS         = DEFAULT_COLS,
    parameter int ROWS         = DEFAULT_ROWS,
    parameter int AW           = 12,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [6:0]    wr_char,
    input  logic [AW-1:0] rd_addr,
    output logic [6:0]    rd_char,
    output logic [6:0]    cur_x,
    output logic [4:0]    cur_y,
    output logic          cursor_on
);

    if (COLS * ROWS > 2 ** AW || COLS > 128 || ROWS > 32 || BLINK_CYCLES < 1) begin : g_cfg_check
        $error("text_console_writer: illegal COLS/ROWS/AW/BLINK_CYCLES combination");
    end

    localparam logic [AW-1:0] LAST_CELL  = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] LAST_COL_A = AW'(COLS - 1);
    localparam logic [6:0]    LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]    LAST_ROW   = 5'(ROWS - 1);

    state_t        state, state_n;
    logic [AW-1:0] clr_cnt, clr_cnt_n;
    logic [6:0]    cur_x_n;
    logic [4:0]    cur_y_n;
    logic          row_adv;
    logic          we;
    logic [AW-1:0] waddr;
    logic [6:0]    wdata;
    logic [AW-1:0] row_base;

    assign row_base = AW'(cur_y) * AW'(COLS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            wr_ready <= 1'b0;
        end else begin
            state    <= state_n;
            clr_cnt  <= clr_cnt_n;
            cur_x    <= cur_x_n;
            cur_y    <= cur_y_n;
            wr_ready <= (state_n == ST_IDLE);
        end
    end

    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        cur_x_n   = cur_x;
        cur_y_n   = cur_y;
        row_adv   = 1'b0;
        we        = 1'b0;
        waddr     = '0;
        wdata     = CH_BLANK;

        case (state)
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = clr_cnt;
                if (clr_cnt == LAST_CELL) begin
                    state_n   = ST_IDLE;
                    clr_cnt_n = '0;
                    cur_x_n   = '0;
                    cur_y_n   = '0;
                end else begin
                    clr_cnt_n = clr_cnt + AW'(1);
                end
            end

            ST_IDLE: begin
                if (wr_valid && wr_ready) begin
                    if (is_printable(wr_char)) begin
                        we    = 1'b1;
                        waddr = row_base + AW'(cur_x);
                        wdata = wr_char;
                        if (cur_x == LAST_COL) begin
                            cur_x_n = '0;
                            row_adv = 1'b1;
                        end else begin
                            cur_x_n = cur_x + 7'd1;
                        end
                    end else if (wr_char == CH_NL) begin
                        cur_x_n = '0;
                        row_adv = 1'b1;
                    end else if (wr_char == CH_BS) begin
                        if (cur_x != '0) begin
                            cur_x_n = cur_x - 7'd1;
                            we      = 1'b1;
                            waddr   = row_base + AW'(cur_x - 7'd1);
                        end
                    end else if (wr_char == CH_FF) begin
                        // Home now as well as on exit so the cursor never points at stale text.
                        state_n   = ST_CLEAR;
                        clr_cnt_n = '0;
                        cur_x_n   = '0;
                        cur_y_n   = '0;
                    end
                end
            end

            ST_CLR_LINE: begin
                we    = 1'b1;
                waddr = row_base + clr_cnt;
                if (clr_cnt == LAST_COL_A) begin
                    state_n   = ST_IDLE;
                    clr_cnt_n = '0;
                end else begin
                    clr_cnt_n = clr_cnt + AW'(1);
                end
            end

            default: begin
                state_n   = ST_CLEAR;
                clr_cnt_n = '0;
            end
        endcase

        // Running off the bottom wraps to row 0, which must be blanked before reuse.
        if (row_adv) begin
            if (cur_y != LAST_ROW) begin
                cur_y_n = cur_y + 5'd1;
            end else begin
                cur_y_n   = '0;
                state_n   = ST_CLR_LINE;
                clr_cnt_n = '0;
            end
        end
    end

    tile_ram #(
        .AW    (AW),
        .DW    (7),
        .DEPTH (COLS * ROWS)
    ) u_tile_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .rd_addr (rd_addr),
        .rd_data (rd_char)
    );

`ifdef TEXT_CURSOR_BLINK_EN
    logic [31:0] blink_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            cursor_on <= 1'b1;
        end else if (wr_valid && wr_ready) begin
            blink_cnt <= '0;
            cursor_on <= 1'b1;
        end else if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            cursor_on <= ~cursor_on;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end
`else
    assign cursor_on = 1'b1;
`endif

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a screen-level reference model and per-cycle compare.
module tb_text_console_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int AW   = 12;
    localparam int N    = COLS * ROWS;
`ifdef TEXT_CURSOR_BLINK_EN
    localparam int BLINK = 4;
`else
    localparam int BLINK = 12_500_000;
`endif

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          wr_valid = 1'b0;
    logic [6:0]    wr_char  = 7'h00;
    logic [AW-1:0] rd_addr  = '0;
    logic          wr_ready;
    logic [6:0]    rd_char;
    logic [6:0]    cur_x;
    logic [4:0]    cur_y;
    logic          cursor_on;

    text_console_writer #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .AW           (AW),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_char   (wr_char),
        .rd_addr   (rd_addr),
        .rd_char   (rd_char),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .cursor_on (cursor_on)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Screen model: text grid, cursor, and the number of busy cycles still owed by a clear.
    logic [6:0] mem [0:N-1];
    int         mx = 0, my = 0, busy = N, since = 0;
    bit         m_rst = 1'b1, m_live = 1'b0, rd_ok = 1'b0;
    logic [6:0] m_rd = 7'h00;

    function automatic void adv_row();
        if (my < ROWS - 1) begin
            my++;
        end else begin
            my = 0;
            for (int i = 0; i < COLS; i++) mem[i] = 7'h00;
            busy = COLS;
        end
    endfunction

    function automatic void model_char(input logic [6:0] c);
        if (c >= 7'h20 && c <= 7'h7E) begin
            mem[my * COLS + mx] = c;
            mx++;
            if (mx == COLS) begin
                mx = 0;
                adv_row();
            end
        end else if (c == 7'h0A) begin
            mx = 0;
            adv_row();
        end else if (c == 7'h08) begin
            if (mx > 0) begin
                mx--;
                mem[my * COLS + mx] = 7'h00;
            end
        end else if (c == 7'h0C) begin
            for (int i = 0; i < N; i++) mem[i] = 7'h00;
            mx = 0;
            my = 0;
            busy = N;
        end
    endfunction

    always @(posedge clk) begin
        m_live = 1'b1;
        if (!reset_n) begin
            m_rst = 1'b1;
            busy  = N;
            mx    = 0;
            my    = 0;
            rd_ok = 1'b0;
            since = 0;
        end else begin
            m_rst = 1'b0;
            rd_ok = (busy == 0);
            m_rd  = mem[rd_addr];
            if (busy > 0) begin
                busy--;
                since++;
            end else if (wr_valid) begin
                model_char(wr_char);
                since = 0;
            end else begin
                since++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_live) begin
            chk("cur_x", cur_x, mx);
            chk("cur_y", cur_y, my);
            chk("wr_ready", wr_ready, int'(!m_rst && busy == 0));
`ifdef TEXT_CURSOR_BLINK_EN
            chk("cursor_on", cursor_on, int'(((since / BLINK) % 2) == 0));
`else
            chk("cursor_on", cursor_on, 1);
`endif
            if (m_rst) chk("rd_char_reset", rd_char, 0);
            else if (rd_ok) chk("rd_char", rd_char, m_rd);
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (!wr_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("ready_timeout", wr_ready, 1);
    endtask

    task automatic send(input logic [6:0] c);
        int n;
        wait_ready(n);
        wr_valid = 1'b1;
        wr_char  = c;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic read_at(input int addr, input int exp);
        rd_addr = AW'(addr);
        @(negedge clk);
        chk($sformatf("rd[%0d]", addr), rd_char, exp);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) mem[i] = 7'h00;

        // Power-up clear with a character already waiting.
        wr_valid = 1'b1;
        wr_char  = 7'h41;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_ready(n);
        chk("clear_len", n, 2400);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("a_cur_x", cur_x, 1);
        chk("a_cur_y", cur_y, 0);
        read_at(0, 7'h41);
        read_at(2399, 7'h00);
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
        end

        // Erase the 'A' then stream a full row back-to-back.
        send(7'h08);
        chk("bs_home_x", cur_x, 0);
        wait_ready(n);
        wr_valid = 1'b1;
        wr_char  = 7'h42;
        for (int i = 0; i < COLS; i++) begin
            @(negedge clk);
            chk("burst_ready", wr_ready, 1);
        end
        wr_valid = 1'b0;
        chk("burst_x", cur_x, 0);
        chk("burst_y", cur_y, 1);
        read_at(0, 7'h42);
        read_at(79, 7'h42);
        read_at(80, 7'h00);

        // Walk to (5,29) then wrap with a newline.
        for (int i = 0; i < 28; i++) send(7'h0A);
        for (int i = 0; i < 5; i++) send(7'h43);
        chk("pre_wrap_x", cur_x, 5);
        chk("pre_wrap_y", cur_y, 29);
        send(7'h0A);
        wait_ready(n);
        chk("clr_line_len", n, 80);
        chk("wrap_x", cur_x, 0);
        chk("wrap_y", cur_y, 0);
        read_at(0, 7'h00);
        read_at(79, 7'h00);
        read_at(29 * COLS, 7'h43);

        // Backspace mid-line and at column 0.
        send(7'h0A);
        send(7'h0A);
        send(7'h61);
        send(7'h62);
        send(7'h63);
        send(7'h08);
        chk("bs_x", cur_x, 2);
        chk("bs_y", cur_y, 2);
        read_at(2 * COLS + 2, 7'h00);
        read_at(2 * COLS + 1, 7'h62);
        send(7'h0A);
        send(7'h0A);
        send(7'h08);
        chk("bs0_x", cur_x, 0);
        chk("bs0_y", cur_y, 4);

        // Ignored codes, then printable range edges.
        send(7'h00);
        send(7'h7F);
        send(7'h01);
        send(7'h1F);
        chk("ign_x", cur_x, 0);
        send(7'h20);
        send(7'h7E);
        chk("edge_x", cur_x, 2);
        read_at(4 * COLS, 7'h20);
        read_at(4 * COLS + 1, 7'h7E);

        // Form feed.
        send(7'h58);
        send(7'h0C);
        wait_ready(n);
        chk("ff_clear_len", n, 2400);
        send(7'h59);
        chk("ff_x", cur_x, 1);
        chk("ff_y", cur_y, 0);
        read_at(0, 7'h59);
        read_at(1, 7'h00);
        read_at(4 * COLS, 7'h00);

        // Reset in the middle of a clear restarts a full clear.
        send(7'h0C);
        repeat (1000) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", wr_ready, 0);
        reset_n = 1'b1;
        wait_ready(n);
        chk("rst_clear_len", n, 2400);
        chk("rst_x", cur_x, 0);
        chk("rst_y", cur_y, 0);
        read_at(0, 7'h00);
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
